// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: queued words go out back-to-back on rs232_tx.
// Ports: CLK, RSTn (async low), wr_en/wr_data push side; full/empty/level FIFO status;
//        rs232_tx serial line (idle high), busy (start..last stop), tx_done (last stop cycle).
// Optional macro UART_TX_OVF_EN adds ovf_clr input and sticky ovf output (dropped push).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 56,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_AW      = 3
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
`ifdef UART_TX_OVF_EN
    input  logic                 ovf_clr,
    output logic                 ovf,
`endif
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_AW:0]     level,
    output logic                 rs232_tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [BAUD_W-1:0]  BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   DATA_MAX = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]   STOP_MAX = BIT_W'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic               PAR_ODD  = (PARITY == 1);
    localparam bit                 PAR_EN   = (PARITY != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t state, state_n;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 baud_last, data_last, stop_last;

    logic tx_n, busy_n, done_n;

    // ---------------- FIFO ----------------
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign level = count;
    // full is the registered occupancy, so a push while full is dropped
    // even when the shifter pops in the same cycle.
    assign push  = wr_en && !full;
    assign head  = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign baud_last = (baud_cnt == BAUD_MAX);
    assign data_last = (bit_cnt == DATA_MAX);
    assign stop_last = (bit_cnt == STOP_MAX);

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_last && data_last) begin
                    state_n = PAR_EN ? PAR : STOP;
                end
            end
            PAR: begin
                if (baud_last) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when work is queued.
                if (baud_last && stop_last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- datapath counters ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
        end else begin
            if (state == IDLE || baud_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (baud_last) begin
                bit_cnt <= (state_n != state) ? '0 : bit_cnt + 1'b1;
            end

            // Parity is taken from the whole word at load time so the
            // shifter can be consumed LSB first.
            if (pop) begin
                shift_q <= head;
                par_q   <= (^head) ^ PAR_ODD;
            end else if (state == DATA && baud_last) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tx_n   = 1'b1;
        busy_n = 1'b1;
        done_n = 1'b0;
        unique case (state)
            IDLE:    busy_n = 1'b0;
            START:   tx_n   = 1'b0;
            DATA:    tx_n   = shift_q[0];
            PAR:     tx_n   = par_q;
            STOP:    done_n = baud_last && stop_last;
            default: busy_n = 1'b0;
        endcase
    end

    // All line-side outputs share one register stage so they stay aligned.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rs232_tx <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            rs232_tx <= tx_n;
            busy     <= busy_n;
            tx_done  <= done_n;
        end
    end

`ifdef UART_TX_OVF_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three configurations,
// line traces compared against frames built from the word list.
module tb_uart_tx_fifo;

    localparam int CPB = 56;
    localparam int FL  = 10 * CPB;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    logic       we0 = 1'b0, we1 = 1'b0, we2 = 1'b0;
    logic [7:0] wd0 = '0, wd1 = '0;
    logic [6:0] wd2 = '0;
    logic       full0, empty0, tx0, busy0, done0;
    logic       full1, empty1, tx1, busy1, done1;
    logic       full2, empty2, tx2, busy2, done2;
    logic [3:0] lvl0, lvl1, lvl2;
`ifdef UART_TX_OVF_EN
    logic clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
    logic ovf0, ovf1, ovf2;
`endif

    uart_tx_fifo u_dut (
        .CLK(CLK), .RSTn(RSTn), .wr_en(we0), .wr_data(wd0),
`ifdef UART_TX_OVF_EN
        .ovf_clr(clr0), .ovf(ovf0),
`endif
        .full(full0), .empty(empty0), .level(lvl0),
        .rs232_tx(tx0), .busy(busy0), .tx_done(done0)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) u_even (
        .CLK(CLK), .RSTn(RSTn), .wr_en(we1), .wr_data(wd1),
`ifdef UART_TX_OVF_EN
        .ovf_clr(clr1), .ovf(ovf1),
`endif
        .full(full1), .empty(empty1), .level(lvl1),
        .rs232_tx(tx1), .busy(busy1), .tx_done(done1)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)
    ) u_odd (
        .CLK(CLK), .RSTn(RSTn), .wr_en(we2), .wr_data(wd2),
`ifdef UART_TX_OVF_EN
        .ovf_clr(clr2), .ovf(ovf2),
`endif
        .full(full2), .empty(empty2), .level(lvl2),
        .rs232_tx(tx2), .busy(busy2), .tx_done(done2)
    );

    logic tx_w[3], busy_w[3], done_w[3];
    assign tx_w[0] = tx0;   assign busy_w[0] = busy0; assign done_w[0] = done0;
    assign tx_w[1] = tx1;   assign busy_w[1] = busy1; assign done_w[1] = done1;
    assign tx_w[2] = tx2;   assign busy_w[2] = busy2; assign done_w[2] = done2;

    int n_checks = 0;
    int n_pass   = 0;

    bit cap_tx[$], cap_busy[$], cap_done[$];
    bit exp_tx[$], exp_busy[$], exp_done[$];

    // Bit idx of a frame: 0 start, 1..nb data LSB first, optional parity, stops.
    function automatic bit frame_bit(input logic [8:0] w, input int idx,
                                     input int nb, input int par);
        logic [8:0] m;
        m = 9'((1 << nb) - 1);
        if (idx == 0) return 1'b0;
        if (idx <= nb) return w[idx-1];
        if (par != 0 && idx == nb + 1) return (^(w & m)) ^ (par == 1);
        return 1'b1;
    endfunction

    // Expected per-cycle trace of contiguous frames, then one idle cycle.
    function automatic void build_expect(input logic [8:0] ws[$], input int nb,
                                         input int par, input int stops,
                                         input int cpb);
        int nbits;
        nbits = 1 + nb + ((par != 0) ? 1 : 0) + stops;
        exp_tx.delete(); exp_busy.delete(); exp_done.delete();
        foreach (ws[k])
            for (int b = 0; b < nbits; b++)
                for (int c = 0; c < cpb; c++) begin
                    exp_tx.push_back(frame_bit(ws[k], b, nb, par));
                    exp_busy.push_back(1'b1);
                    exp_done.push_back(b == nbits - 1 && c == cpb - 1);
                end
        exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
    endfunction

    // Waits (bounded) for the start bit, then records n+1 cycles.
    task automatic capture(input int sel, input int n, output bit ok);
        cap_tx.delete(); cap_busy.delete(); cap_done.delete();
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLK);
            if (tx_w[sel] === 1'b0) ok = 1'b1;
        end
        if (ok)
            for (int i = 0; i <= n; i++) begin
                if (i > 0) @(negedge CLK);
                cap_tx.push_back(tx_w[sel]);
                cap_busy.push_back(busy_w[sel]);
                cap_done.push_back(done_w[sel]);
            end
    endtask

    // Called at a negedge; one word per cycle, returns at a negedge.
    task automatic push_words(input int sel, input logic [8:0] ws[$]);
        foreach (ws[i]) begin
            case (sel)
                0: begin we0 = 1'b1; wd0 = ws[i][7:0]; end
                1: begin we1 = 1'b1; wd1 = ws[i][7:0]; end
                default: begin we2 = 1'b1; wd2 = ws[i][6:0]; end
            endcase
            @(posedge CLK);
            @(negedge CLK);
        end
        we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({tx0, busy0, done0, empty0, full0, lvl0} !== {5'b10010, 4'd0})
            $display("FAIL reset_state: got %b%b%b%b%b lvl %0d want 10010 lvl 0",
                     tx0, busy0, done0, empty0, full0, lvl0);
        else n_pass++;
`ifdef UART_TX_OVF_EN
        n_checks++;
        if (ovf0 !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf0);
        else n_pass++;
`endif
        RSTn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({tx0, busy0, done0, empty0, lvl0, tx1, tx2} !== {4'b1001, 4'd0, 2'b11})
                $display("FAIL idle cyc %0d: tx %b busy %b empty %b lvl %0d want 1 0 1 0",
                         i, tx0, busy0, empty0, lvl0);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [8:0] ws[$];
        ws = '{9'h055};
        build_expect(ws, 8, 0, 1, CPB);
        we0 = 1'b1; wd0 = 8'h55;
        @(posedge CLK); @(negedge CLK);
        we0 = 1'b0;
        n_checks++;
        if ({tx0, busy0, lvl0} !== {2'b10, 4'd1})
            $display("FAIL single_push: tx %b busy %b lvl %0d want 1 0 1", tx0, busy0, lvl0);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if ({tx0, empty0, lvl0} !== {2'b11, 4'd0})
            $display("FAIL single_pop: tx %b empty %b lvl %0d want 1 1 0", tx0, empty0, lvl0);
        else n_pass++;
        capture(0, FL, ok);
        n_checks++;
        if (!ok || cap_tx.size() != exp_tx.size()) begin
            $display("FAIL single_start: no start bit within bound");
        end else begin
            n_pass++;
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                    $display("FAIL single cyc %0d: tx/busy/done %b%b%b want %b%b%b", i,
                             cap_tx[i], cap_busy[i], cap_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [8:0] ws[$];
        ws = '{9'h000, 9'h0FF, 9'h0A5, 9'h03C, 9'h081};
        build_expect(ws, 8, 0, 1, CPB);
        fork
            capture(0, 5 * FL, ok);
            push_words(0, ws);
        join
        n_checks++;
        if (!ok || cap_tx.size() != exp_tx.size()) begin
            $display("FAIL b2b_start: no start bit within bound");
        end else begin
            n_pass++;
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                    $display("FAIL b2b cyc %0d: tx/busy/done %b%b%b want %b%b%b", i,
                             cap_tx[i], cap_busy[i], cap_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [8:0] ws[$];
        for (int r = 0; r < 4; r++) begin
            int sel, n, cpb, fl;
            sel = (r == 3) ? 1 : 0;
            cpb = (sel == 1) ? 8 : CPB;
            fl  = (sel == 1) ? 12 * 8 : FL;
            n   = $urandom_range(1, 9);
            ws.delete();
            for (int k = 0; k < n; k++) ws.push_back(9'($urandom_range(0, 255)));
            if (sel == 1) build_expect(ws, 8, 2, 2, cpb);
            else build_expect(ws, 8, 0, 1, cpb);
            fork
                capture(sel, n * fl, ok);
                push_words(sel, ws);
            join
            n_checks++;
            if (!ok || cap_tx.size() != exp_tx.size()) begin
                $display("FAIL rand%0d_start: no start bit within bound", r);
            end else begin
                n_pass++;
                for (int i = 0; i < exp_tx.size(); i++) begin
                    n_checks++;
                    if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                        $display("FAIL rand%0d cyc %0d: tx/busy/done %b%b%b want %b%b%b", r, i,
                                 cap_tx[i], cap_busy[i], cap_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_parity();
        bit ok;
        logic [8:0] ws[$];
        ws = '{9'h007};
        build_expect(ws, 8, 2, 2, 8);
        fork
            capture(1, 12 * 8, ok);
            push_words(1, ws);
        join
        n_checks++;
        if (!ok || cap_tx.size() != exp_tx.size()) begin
            $display("FAIL even_start: no start bit within bound");
        end else begin
            n_pass++;
            n_checks++;
            if (cap_tx[9 * 8 + 4] !== 1'b1)
                $display("FAIL even_par_bit: got %b want 1", cap_tx[9 * 8 + 4]);
            else n_pass++;
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                    $display("FAIL even cyc %0d: tx/busy/done %b%b%b want %b%b%b", i,
                             cap_tx[i], cap_busy[i], cap_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
                else n_pass++;
            end
        end
        ws = '{9'h007, 9'($urandom_range(0, 127)), 9'($urandom_range(0, 127))};
        build_expect(ws, 7, 1, 1, 4);
        fork
            capture(2, 3 * 10 * 4, ok);
            push_words(2, ws);
        join
        n_checks++;
        if (!ok || cap_tx.size() != exp_tx.size()) begin
            $display("FAIL odd_start: no start bit within bound");
        end else begin
            n_pass++;
            n_checks++;
            if (cap_tx[8 * 4 + 2] !== 1'b0)
                $display("FAIL odd_par_bit: got %b want 0", cap_tx[8 * 4 + 2]);
            else n_pass++;
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                    $display("FAIL odd cyc %0d: tx/busy/done %b%b%b want %b%b%b", i,
                             cap_tx[i], cap_busy[i], cap_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [8:0] ws[$], acc[$];
        for (int k = 0; k < 12; k++) ws.push_back(9'($urandom_range(0, 255)));
        for (int k = 0; k < 9; k++) acc.push_back(ws[k]);
        build_expect(acc, 8, 0, 1, CPB);
        fork
            capture(0, 9 * FL, ok);
            begin
                for (int k = 1; k <= 12; k++) begin
                    int el;
                    // First word leaves for the shifter one cycle later.
                    el = (k == 1) ? 1 : ((k - 1 > 8) ? 8 : k - 1);
                    we0 = 1'b1; wd0 = ws[k-1][7:0];
                    @(posedge CLK); @(negedge CLK);
                    n_checks++;
                    if ({full0, lvl0} !== {(k >= 9), 4'(el)})
                        $display("FAIL ovf_push%0d: full %b lvl %0d want %b %0d",
                                 k, full0, lvl0, (k >= 9), el);
                    else n_pass++;
`ifdef UART_TX_OVF_EN
                    n_checks++;
                    if (ovf0 !== (k >= 10))
                        $display("FAIL ovf_flag%0d: got %b want %b", k, ovf0, (k >= 10));
                    else n_pass++;
`endif
                end
`ifdef UART_TX_OVF_EN
                clr0 = 1'b1;
                @(posedge CLK); @(negedge CLK);
                n_checks++;
                if (ovf0 !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", ovf0);
                else n_pass++;
                we0 = 1'b0;
                @(posedge CLK); @(negedge CLK);
                clr0 = 1'b0;
                n_checks++;
                if (ovf0 !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf0);
                else n_pass++;
`endif
                we0 = 1'b0;
            end
        join
        n_checks++;
        if (!ok || cap_tx.size() != exp_tx.size()) begin
            $display("FAIL ovf_start: no start bit within bound");
        end else begin
            n_pass++;
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                    $display("FAIL ovf cyc %0d: tx/busy/done %b%b%b want %b%b%b", i,
                             cap_tx[i], cap_busy[i], cap_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [8:0] ws[$];
        for (int k = 0; k < 4; k++) ws.push_back(9'($urandom_range(0, 255)));
        push_words(0, ws);
        repeat (3 * CPB) @(negedge CLK);
        n_checks++;
        if ({busy0, lvl0} !== {1'b1, 4'd3})
            $display("FAIL mid_pre: busy %b lvl %0d want 1 3", busy0, lvl0);
        else n_pass++;
        #2 RSTn = 1'b0;
        #1;
        n_checks++;
        if ({tx0, busy0, done0, empty0, full0, lvl0} !== {5'b10010, 4'd0})
            $display("FAIL mid_reset: tx %b busy %b empty %b lvl %0d want 1 0 1 0",
                     tx0, busy0, empty0, lvl0);
        else n_pass++;
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({tx0, busy0, empty0} !== 3'b101)
                $display("FAIL mid_idle cyc %0d: tx %b busy %b empty %b want 1 0 1",
                         i, tx0, busy0, empty0);
            else n_pass++;
        end
        ws = '{9'($urandom_range(0, 255))};
        build_expect(ws, 8, 0, 1, CPB);
        fork
            capture(0, FL, ok);
            push_words(0, ws);
        join
        n_checks++;
        if (!ok || cap_tx.size() != exp_tx.size()) begin
            $display("FAIL mid_after_start: no start bit within bound");
        end else begin
            n_pass++;
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {exp_tx[i], exp_busy[i], exp_done[i]})
                    $display("FAIL mid_after cyc %0d: tx/busy/done %b%b%b want %b%b%b", i,
                             cap_tx[i], cap_busy[i], cap_done[i], exp_tx[i], exp_busy[i], exp_done[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_parity();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an input FIFO; successor to the fixed 8N1 serial stimulus path driving rs232_rx of uart_top.
- Host side pushes words into the FIFO; the block serialises them back-to-back onto rs232_tx.
- Frame format is configurable: data width, parity mode, stop-bit count and baud divisor.
- Used as synthesizable loopback/stimulus source and as TX path of the next UART top.

Parameters:
CLKS_PER_BIT, 56, clock cycles per serial bit (>=2); 56 gives 560 ns/bit at 100 MHz.
DATA_BITS, 8, data bits per frame (5..9).
PARITY, 0, 0=none, 1=odd, 2=even.
STOP_BITS, 1, stop bits per frame (1 or 2).
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW.

Ports:
CLK  in  1  system clock, rising edge.
RSTn  in  1  asynchronous active-low reset.
wr_en  in  1  push request.
wr_data  in  DATA_BITS  word to push.
full  out  1  FIFO holds 2**FIFO_AW words.
empty  out  1  FIFO holds 0 words.
level  out  FIFO_AW+1  FIFO occupancy (excludes word in shifter).
rs232_tx  out  1  serial line, idle high, registered.
busy  out  1  high from start bit through last stop bit.
tx_done  out  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (RSTn low, async): rs232_tx=1, busy=0, tx_done=0, empty=1, full=0, level=0, FSM=IDLE, FIFO pointers cleared, bit/baud counters 0. Reset mid-frame aborts the frame immediately; line returns high; queued words are discarded.
- FIFO: push when wr_en && !full. full is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs that cycle. Pop and push in the same cycle leave level unchanged. Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: if !empty, pop head into shifter, go to START. A word written at edge N into an empty FIFO is popped at edge N+1; rs232_tx goes low after edge N+2.
- START: rs232_tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles. Then PAR if PARITY!=0, else STOP.
- PAR: even parity = XOR of data bits; odd parity = its inverse.
- STOP: rs232_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done pulses in the last cycle.
- End of STOP: if !empty in the last STOP cycle, pop and go directly to START (no idle gap, frames contiguous); else go to IDLE.
- busy=1 in START/DATA/PAR/STOP; busy=0 in IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; width is clog2(CLKS_PER_BIT).
- Frame length: 1+DATA_BITS+(PARITY!=0)+STOP_BITS bits.

Optional Feature:
- Macro UART_TX_OVF_EN.
- Defined: adds input ovf_clr (1) and output ovf (1). ovf is set sticky on any push dropped because full. ovf_clr clears it; set wins over a same-cycle clear. Reset value 0.
- Undefined: neither port exists; dropped pushes are silent.

Test Plan:
- Reset then idle 1000 cycles -> rs232_tx=1, busy=0, empty=1, level=0 throughout.
- Defaults, push 0x55 -> low start 56 cycles, bits 1,0,1,0,1,0,1,0 at 56 cycles each, stop high 56; tx_done pulses once, 560 cycles after start edge.
- Push 0x00,0xFF,0xA5,0x3C,0x81 on consecutive cycles -> five contiguous frames totalling 2800 cycles of busy=1, no idle gap, correct LSB-first data, 5 tx_done pulses.
- PARITY=2, STOP_BITS=2, push 0x07 -> parity bit 1, then 112 high cycles before tx_done; PARITY=1 -> parity bit 0.
- Defaults, 12 pushes on consecutive cycles from idle -> 9 accepted (1 in shifter + 8 queued), full=1 after 9th, 3 dropped, ovf=1 (macro on), ovf_clr clears it; 9 frames transmitted.
- RSTn low mid-DATA of a frame with 3 words queued -> rs232_tx=1 immediately, level=0; after release, no frame is sent until a new push.
